pc_stack_unit: RTL and testbench

- Parametrised successor to the single-register program counter: holds the PC and updates it by increment, absolute jump, signed relative branch, call or return.
- Adds a hardware return-address LIFO with full/empty status and sticky overflow/underflow error flags.
- Sits between the FSM, which drives the op and enable, and the memory address mux, which consumes `pc_out`.
- The absolute target comes from register mux A; the relative offset comes from the instruction immediate.

---
 rtl/pc_stack_pkg.sv | 14 +
 rtl/addr_lifo.sv | 65 ++++++
 rtl/pc_stack_unit.sv | 114 +++++++++++
 tb/tb_pc_stack_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_stack_pkg.sv
// Shared definitions for the program-counter / return-stack unit.
//   OP_WIDTH : width of the pc_op select
//   PC_*     : pc_op encodings; codes 5..7 are reserved and act as no-ops
package pc_stack_pkg;

  localparam int unsigned OP_WIDTH = 3;

  localparam logic [OP_WIDTH-1:0] PC_INC  = 3'd0;
  localparam logic [OP_WIDTH-1:0] PC_JMP  = 3'd1;
  localparam logic [OP_WIDTH-1:0] PC_BR   = 3'd2;
  localparam logic [OP_WIDTH-1:0] PC_CALL = 3'd3;
  localparam logic [OP_WIDTH-1:0] PC_RET  = 3'd4;

endpackage

// File: rtl/addr_lifo.sv
// Return-address LIFO.
//   clk, reset : rising-edge clock, async active-high reset (pointer only)
//   push, pop  : request a push of din / a pop of the top entry
//   din        : address to push
//   dout       : top-of-stack entry, 0 when empty
//   depth      : number of valid entries
//   full/empty : depth == STACK_DEPTH / depth == 0
//   push_rej   : push requested while full (request ignored)
//   pop_rej    : pop requested while empty (request ignored)
module addr_lifo #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned STACK_DEPTH = 8,
  parameter int unsigned DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] din,
  output logic [ADDR_WIDTH-1:0] dout,
  output logic [DEPTH_W-1:0]    depth,
  output logic                  full,
  output logic                  empty,
  output logic                  push_rej,
  output logic                  pop_rej
);

  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_WIDTH-1:0] mem [STACK_DEPTH];
  logic [DEPTH_W-1:0]    count;
  logic [IDX_W-1:0]      wr_idx;
  logic [IDX_W-1:0]      rd_idx;
  logic                  do_push;
  logic                  do_pop;

  assign wr_idx   = IDX_W'(count);
  assign rd_idx   = IDX_W'(count - DEPTH_W'(1));
  assign full     = (count == DEPTH_W'(STACK_DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign push_rej = push & full;
  assign pop_rej  = pop & empty;
  assign depth    = count;
  assign dout     = empty ? '0 : mem[rd_idx];

  // Simultaneous push and pop replaces the top entry in place.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[do_pop ? rd_idx : wr_idx] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (do_push && !do_pop) begin
      count <= count + DEPTH_W'(1);
    end else if (do_pop && !do_push) begin
      count <= count - DEPTH_W'(1);
    end
  end

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with hardware return-address stack.
//   clk, reset : rising-edge clock, async active-high reset
//   pc_en      : apply pc_op this cycle; otherwise PC and stack hold
//   pc_op      : INC / JMP / BR / CALL / RET (5..7 reserved, no effect)
//   target     : absolute destination for JMP and CALL
//   offset     : two's-complement displacement for BR
//   err_clr    : clears the sticky ovf/udf flags (a same-edge error wins)
//   pc_out     : registered program counter
//   tos        : top-of-stack return address, 0 when empty
//   depth      : number of stacked return addresses
//   full/empty : stack status
//   ovf        : sticky, CALL attempted while full
//   udf        : sticky, RET attempted while empty
module pc_stack_unit
  import pc_stack_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH   = 12,
  parameter int unsigned           STACK_DEPTH  = 8,
  parameter int unsigned           OFF_WIDTH    = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             pc_en,
  input  logic [OP_WIDTH-1:0]              pc_op,
  input  logic [ADDR_WIDTH-1:0]            target,
  input  logic [OFF_WIDTH-1:0]             offset,
  input  logic                             err_clr,
  output logic [ADDR_WIDTH-1:0]            pc_out,
  output logic [ADDR_WIDTH-1:0]            tos,
  output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
  output logic                             full,
  output logic                             empty,
  output logic                             ovf,
  output logic                             udf
);

  localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] off_ext;
  logic                  push;
  logic                  pop;
  logic                  push_rej;
  logic                  pop_rej;

  assign pc_inc  = pc + ADDR_WIDTH'(1);
  assign off_ext = ADDR_WIDTH'($signed(offset));

  addr_lifo #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .STACK_DEPTH (STACK_DEPTH),
    .DEPTH_W     (DEPTH_W)
  ) u_lifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .din      (pc_inc),
    .dout     (tos),
    .depth    (depth),
    .full     (full),
    .empty    (empty),
    .push_rej (push_rej),
    .pop_rej  (pop_rej)
  );

  // CALL jumps even when the push is refused; RET on an empty stack
  // degrades to an increment.
  always_comb begin
    pc_next = pc;
    push    = 1'b0;
    pop     = 1'b0;
    if (pc_en) begin
      case (pc_op)
        PC_INC:  pc_next = pc_inc;
        PC_JMP:  pc_next = target;
        PC_BR:   pc_next = pc + off_ext;
        PC_CALL: begin
          push    = 1'b1;
          pc_next = target;
        end
        PC_RET: begin
          pop     = 1'b1;
          pc_next = empty ? pc_inc : tos;
        end
        default: pc_next = pc;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_VECTOR;
    end else begin
      pc <= pc_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= push_rej | (ovf & ~err_clr);
      udf <= pop_rej  | (udf & ~err_clr);
    end
  end

  assign pc_out = pc;

endmodule

// File: tb/tb_pc_stack_unit.sv
module tb_pc_stack_unit;

  localparam int AW   = 12;
  localparam int SD   = 8;
  localparam int MASK = 32'hFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pc_en = 1'b0;
  logic [2:0]  pc_op = 3'd0;
  logic [11:0] target = '0;
  logic [7:0]  offset = '0;
  logic        err_clr = 1'b0;
  logic [11:0] pc_out;
  logic [11:0] tos;
  logic [3:0]  depth;
  logic        full, empty, ovf, udf;

  int total = 0;
  int bad = 0;
  bit checking = 0;

  // Reference model: PC as an integer, the stack as a queue.
  int m_pc;
  int m_stk[$];
  bit m_ovf, m_udf;

  pc_stack_unit #(
    .ADDR_WIDTH   (AW),
    .STACK_DEPTH  (SD),
    .OFF_WIDTH    (8),
    .RESET_VECTOR (12'h000)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .pc_en   (pc_en),
    .pc_op   (pc_op),
    .target  (target),
    .offset  (offset),
    .err_clr (err_clr),
    .pc_out  (pc_out),
    .tos     (tos),
    .depth   (depth),
    .full    (full),
    .empty   (empty),
    .ovf     (ovf),
    .udf     (udf)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0;
    m_stk.delete();
    m_ovf = 0;
    m_udf = 0;
  endtask

  task automatic model_step(bit en, int op, int tgt, int off, bit clr);
    bit oe = 0;
    bit ue = 0;
    int d;
    if (en) begin
      case (op)
        0: m_pc = (m_pc + 1) & MASK;
        1: m_pc = tgt & MASK;
        2: begin
          d = off;
          if (d >= 128) d = d - 256;
          m_pc = (m_pc + d) & MASK;
        end
        3: begin
          if (m_stk.size() < SD) m_stk.push_back((m_pc + 1) & MASK);
          else oe = 1;
          m_pc = tgt & MASK;
        end
        4: begin
          if (m_stk.size() > 0) m_pc = m_stk.pop_back();
          else begin
            m_pc = (m_pc + 1) & MASK;
            ue = 1;
          end
        end
        default: ;
      endcase
    end
    m_ovf = oe ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_udf = ue ? 1'b1 : (clr ? 1'b0 : m_udf);
  endtask

  task automatic step(bit en, int op, int tgt, int off, bit clr);
    pc_en   = en;
    pc_op   = op[2:0];
    target  = tgt[11:0];
    offset  = off[7:0];
    err_clr = clr;
    @(posedge clk);
    model_step(en, op, tgt, off, clr);
    #1;
  endtask

  task automatic do_reset();
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_reset_pc", int'(pc_out), 0);
    chk("async_reset_depth", int'(depth), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("pc_out", int'(pc_out), m_pc);
      chk("depth", int'(depth), m_stk.size());
      chk("tos", int'(tos), (m_stk.size() > 0) ? m_stk[$] : 0);
      chk("full", int'(full), (m_stk.size() == SD) ? 1 : 0);
      chk("empty", int'(empty), (m_stk.size() == 0) ? 1 : 0);
      chk("ovf", int'(ovf), int'(m_ovf));
      chk("udf", int'(udf), int'(m_udf));
    end
  end

  initial begin
    int r, op, exp_pc, sv_pc;
    model_reset();
    checking = 1;
    #1;
    chk("rst_pc", int'(pc_out), 0);
    chk("rst_tos", int'(tos), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_flags", int'({ovf, udf}), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Increment, hold, async reset
    for (int i = 1; i <= 3; i++) begin
      step(1, 0, 0, 0, 0);
      chk("inc_seq", int'(pc_out), i);
    end
    step(0, 0, 0, 0, 0);
    step(0, 1, 12'h777, 0, 0);
    chk("hold_pc", int'(pc_out), 3);
    do_reset();

    // Relative branch with wrap both ways
    step(1, 1, 12'h00A, 0, 0);
    step(1, 2, 0, 8'hF6, 0);
    chk("br_neg10", int'(pc_out), 0);
    step(1, 2, 0, 8'hFF, 0);
    chk("br_wrap_down", int'(pc_out), 12'hFFF);
    step(1, 0, 0, 0, 0);
    chk("inc_wrap", int'(pc_out), 0);

    // Nested calls
    step(1, 1, 12'h010, 0, 0);
    step(1, 3, 12'h100, 0, 0);
    chk("call1_pc", int'(pc_out), 12'h100);
    chk("call1_tos", int'(tos), 12'h011);
    chk("call1_depth", int'(depth), 1);
    step(1, 3, 12'h200, 0, 0);
    chk("call2_depth", int'(depth), 2);
    chk("call2_tos", int'(tos), 12'h101);
    step(1, 4, 0, 0, 0);
    chk("ret1_pc", int'(pc_out), 12'h101);
    step(1, 4, 0, 0, 0);
    chk("ret2_pc", int'(pc_out), 12'h011);
    chk("ret2_empty", int'(empty), 1);

    // Fill, overflow, set-wins, LIFO unwind
    step(1, 1, 12'h040, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 3, 12'h500 + 16 * i, 0, 0);
    chk("fill_full", int'(full), 1);
    chk("fill_tos", int'(tos), 12'h561);
    step(1, 3, 12'h3FF, 0, 0);
    chk("ovf_pc", int'(pc_out), 12'h3FF);
    chk("ovf_depth", int'(depth), 8);
    chk("ovf_flag", int'(ovf), 1);
    chk("ovf_tos", int'(tos), 12'h561);
    step(1, 3, 12'h3FF, 0, 1);
    chk("ovf_set_wins", int'(ovf), 1);
    for (int k = 0; k < 8; k++) begin
      exp_pc = (k < 7) ? (12'h561 - 16 * k) : 12'h041;
      step(1, 4, 0, 0, (k == 0));
      chk("unwind_pc", int'(pc_out), exp_pc);
      if (k == 0) chk("ovf_cleared", int'(ovf), 0);
    end
    chk("unwind_empty", int'(empty), 1);

    // Underflow and sticky clear
    step(1, 1, 12'h020, 0, 0);
    step(1, 4, 0, 0, 0);
    chk("udf_pc", int'(pc_out), 12'h021);
    chk("udf_flag", int'(udf), 1);
    chk("udf_depth", int'(depth), 0);
    step(0, 0, 0, 0, 1);
    chk("udf_clr", int'(udf), 0);
    step(1, 4, 0, 0, 1);
    chk("udf_set_wins", int'(udf), 1);

    // Reserved op
    sv_pc = int'(pc_out);
    step(1, 6, 12'h123, 8'h55, 0);
    chk("rsv_pc", int'(pc_out), sv_pc);
    chk("rsv_depth", int'(depth), 0);
    chk("rsv_flags", int'({ovf, udf}), 1);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        r = $urandom_range(0, 99);
        if (r < 25)      op = 3;
        else if (r < 50) op = 4;
        else if (r < 65) op = 0;
        else if (r < 75) op = 1;
        else if (r < 90) op = 2;
        else             op = $urandom_range(5, 7);
        step(($urandom_range(0, 9) != 0), op, $urandom_range(0, 4095),
             $urandom_range(0, 255), ($urandom_range(0, 9) == 0));
      end
    end

    step(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    checking = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
